// File: rtl/data_ram_ctrl_pkg.sv
// Shared memory-subsystem types and defaults for the TI170 datapath.
// Holds the controller state encoding and the index-width helper.
package ti170_mem_pkg;

  typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_e;

  localparam int TI170_DATA_W = 8;
  localparam int TI170_ADDR_W = 8;
  localparam int TI170_DEPTH  = 128;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/data_ram_ctrl_if.sv
// Load/store request and registered response bus between execute stage and data RAM.
interface data_ram_ctrl_if #(
  parameter int DATA_W = ti170_mem_pkg::TI170_DATA_W,
  parameter int ADDR_W = ti170_mem_pkg::TI170_ADDR_W
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/data_ram_ctrl_ram_sp.sv
// Single-port synchronous array, read-first, 1-cycle read; read data only moves when enabled.
module ram_sp #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 128,
  parameter int IDX_W  = 7
) (
  input  logic              i_clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      o_rdata <= r_mem[i_addr];
    end
  end
endmodule

// File: rtl/data_ram_ctrl.sv
// Data RAM controller: window decode, 1-cycle registered response, zero-fill sequence after reset.
module data_ram_ctrl
  import ti170_mem_pkg::*;
#(
  parameter int DATA_W         = TI170_DATA_W,
  parameter int ADDR_W         = TI170_ADDR_W,
  parameter int DEPTH          = TI170_DEPTH,
  parameter int BASE_ADDR      = 0,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  data_ram_ctrl_if.slave    bus
);
  localparam int                IDX_W  = idx_width(DEPTH);
  localparam logic [ADDR_W:0]   BASE_X = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  state_e             r_state, w_next;
  logic [IDX_W-1:0]   r_clr_idx;
  logic               w_ready, w_busy, w_clr_we;

  // One extra bit so BASE_ADDR+DEPTH at the top of the address space cannot wrap.
  logic [ADDR_W:0]    w_off;
  logic               w_in_range, w_accept, w_hit;
  assign w_off      = {1'b0, bus.req_addr} - BASE_X;
  assign w_in_range = ({1'b0, bus.req_addr} >= BASE_X) && (w_off < DEPTH_X);
  assign w_accept   = bus.req_valid && w_ready && !reset;
  assign w_hit      = w_accept && w_in_range;

  always_ff @(posedge clock) begin
    if (reset) r_state <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_CLEAR: if (r_clr_idx == LAST_IDX) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ready  = 1'b0;
    w_busy   = 1'b0;
    w_clr_we = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_busy   = 1'b1;
        w_clr_we = 1'b1;
      end
      default: w_ready = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)                    r_clr_idx <= '0;
    else if (r_state == ST_CLEAR) r_clr_idx <= (r_clr_idx == LAST_IDX) ? '0 : r_clr_idx + 1'b1;
  end

  logic              w_ram_en, w_ram_we;
  logic [IDX_W-1:0]  w_ram_addr;
  logic [DATA_W-1:0] w_ram_wdata, w_ram_rdata;
  assign w_ram_en    = w_clr_we || w_hit;
  assign w_ram_we    = w_clr_we || (w_hit && bus.req_write);
  assign w_ram_addr  = w_clr_we ? r_clr_idx : w_off[IDX_W-1:0];
  assign w_ram_wdata = w_clr_we ? '0 : bus.req_wdata;

  ram_sp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_ram (
    .i_clk   (clock),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  // Load data comes straight from the array's read register during the valid cycle,
  // then is captured into r_rsp_rdata so it holds while rsp_valid is low.
  logic              r_rsp_valid, r_rsp_err, r_rsp_from_ram;
  logic [DATA_W-1:0] r_rsp_rdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rsp_valid    <= 1'b0;
      r_rsp_err      <= 1'b0;
      r_rsp_from_ram <= 1'b0;
      r_rsp_rdata    <= '0;
    end else begin
      r_rsp_valid    <= w_accept;
      r_rsp_from_ram <= 1'b0;
      if (r_rsp_from_ram) r_rsp_rdata <= w_ram_rdata;
      if (w_accept) begin
        r_rsp_err <= !w_in_range;
        if (!w_in_range)          r_rsp_rdata    <= '0;
        else if (bus.req_write)   r_rsp_rdata    <= bus.req_wdata;
        else                      r_rsp_from_ram <= 1'b1;
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.busy      = w_busy;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_from_ram ? w_ram_rdata : r_rsp_rdata;
endmodule

// File: tb/tb_data_ram_ctrl.sv
// Directed vector bench for data_ram_ctrl across default, windowed and no-clear configurations.
module tb_data_ram_ctrl;
  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wd;
    logic [7:0] exp_d;
    logic       exp_e;
  } vec_t;

  logic       clk;
  logic [2:0] rst;
  int         sel;
  logic       t_valid, t_write;
  logic [7:0] t_addr, t_wdata;
  logic       o_ready, o_busy, o_vld, o_err;
  logic [7:0] o_rdata;
  int         checks, errors;

  data_ram_ctrl_if #(.DATA_W(8), .ADDR_W(8)) ifa ();
  data_ram_ctrl_if #(.DATA_W(8), .ADDR_W(8)) ifb ();
  data_ram_ctrl_if #(.DATA_W(8), .ADDR_W(8)) ifc ();

  data_ram_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(128), .BASE_ADDR(0), .CLEAR_ON_RESET(1'b1))
    dut_a (.clock(clk), .reset(rst[0]), .bus(ifa));
  data_ram_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .BASE_ADDR(8'h40), .CLEAR_ON_RESET(1'b1))
    dut_b (.clock(clk), .reset(rst[1]), .bus(ifb));
  data_ram_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(128), .BASE_ADDR(0), .CLEAR_ON_RESET(1'b0))
    dut_c (.clock(clk), .reset(rst[2]), .bus(ifc));

  assign ifa.req_valid = t_valid && (sel == 0);
  assign ifb.req_valid = t_valid && (sel == 1);
  assign ifc.req_valid = t_valid && (sel == 2);
  assign ifa.req_write = t_write;
  assign ifb.req_write = t_write;
  assign ifc.req_write = t_write;
  assign ifa.req_addr  = t_addr;
  assign ifb.req_addr  = t_addr;
  assign ifc.req_addr  = t_addr;
  assign ifa.req_wdata = t_wdata;
  assign ifb.req_wdata = t_wdata;
  assign ifc.req_wdata = t_wdata;

  always_comb begin
    case (sel)
      1: begin
        o_ready = ifb.req_ready; o_busy = ifb.busy; o_vld = ifb.rsp_valid;
        o_err = ifb.rsp_err; o_rdata = ifb.rsp_rdata;
      end
      2: begin
        o_ready = ifc.req_ready; o_busy = ifc.busy; o_vld = ifc.rsp_valid;
        o_err = ifc.rsp_err; o_rdata = ifc.rsp_rdata;
      end
      default: begin
        o_ready = ifa.req_ready; o_busy = ifa.busy; o_vld = ifa.rsp_valid;
        o_err = ifa.rsp_err; o_rdata = ifa.rsp_rdata;
      end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    t_valid = 1'b1;
    t_write = v.wr;
    t_addr  = v.addr;
    t_wdata = v.wd;
    @(posedge clk); #1;
    check({tag, ".vld"},   32'(o_vld),   32'd1);
    check({tag, ".rdata"}, 32'(o_rdata), 32'(v.exp_d));
    check({tag, ".err"},   32'(o_err),   32'(v.exp_e));
  endtask

  // Called #1 after the last reset edge; counts edges until req_ready rises.
  task automatic wait_ready(input int exp_n, input string tag);
    int  n = 0;
    bit  bad = 1'b0;
    do begin
      @(posedge clk); #1;
      n++;
      if (!o_ready && !o_busy) bad = 1'b1;
      if (o_ready && o_busy)   bad = 1'b1;
    end while (!o_ready && n < 400);
    check({tag, ".cycles"}, 32'(n), 32'(exp_n));
    check({tag, ".busy_held"}, 32'(bad), 32'd0);
    check({tag, ".busy_end"}, 32'(o_busy), 32'd0);
  endtask

  vec_t va[11];
  vec_t vb[8];
  vec_t vz[3];

  initial begin
    checks = 0; errors = 0;
    va[0]  = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
    va[1]  = '{1'b0, 8'h40, 8'h00, 8'h00, 1'b0};
    va[2]  = '{1'b0, 8'h7F, 8'h00, 8'h00, 1'b0};
    va[3]  = '{1'b1, 8'h10, 8'hA5, 8'hA5, 1'b0};
    va[4]  = '{1'b0, 8'h10, 8'h00, 8'hA5, 1'b0};
    va[5]  = '{1'b1, 8'h80, 8'h3C, 8'h00, 1'b1};
    va[6]  = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
    va[7]  = '{1'b0, 8'hFF, 8'h00, 8'h00, 1'b1};
    va[8]  = '{1'b1, 8'h7F, 8'h11, 8'h11, 1'b0};
    va[9]  = '{1'b0, 8'h7F, 8'h00, 8'h11, 1'b0};
    va[10] = '{1'b0, 8'h10, 8'h00, 8'hA5, 1'b0};
    vb[0]  = '{1'b1, 8'h3F, 8'h01, 8'h00, 1'b1};
    vb[1]  = '{1'b1, 8'h50, 8'h02, 8'h00, 1'b1};
    vb[2]  = '{1'b1, 8'h40, 8'h12, 8'h12, 1'b0};
    vb[3]  = '{1'b1, 8'h4F, 8'h34, 8'h34, 1'b0};
    vb[4]  = '{1'b0, 8'h4F, 8'h00, 8'h34, 1'b0};
    vb[5]  = '{1'b0, 8'h40, 8'h00, 8'h12, 1'b0};
    vb[6]  = '{1'b0, 8'h50, 8'h00, 8'h00, 1'b1};
    vb[7]  = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b1};
    vz[0]  = '{1'b0, 8'h22, 8'h00, 8'h00, 1'b0};
    vz[1]  = '{1'b0, 8'h10, 8'h00, 8'h00, 1'b0};
    vz[2]  = '{1'b0, 8'h7F, 8'h00, 8'h00, 1'b0};

    sel = 0; rst = 3'b111;
    t_valid = 1'b0; t_write = 1'b0; t_addr = 8'h00; t_wdata = 8'h00;

    // Default config: reset state, clear length, basic table
    repeat (2) @(posedge clk);
    #1;
    check("a.rst.busy",  32'(o_busy),  32'd1);
    check("a.rst.ready", 32'(o_ready), 32'd0);
    check("a.rst.vld",   32'(o_vld),   32'd0);
    check("a.rst.rdata", 32'(o_rdata), 32'd0);
    check("a.rst.err",   32'(o_err),   32'd0);
    rst[0] = 1'b0;
    wait_ready(128, "a.clr1");
    for (int i = 0; i < 11; i++) apply(va[i], $sformatf("a.vec%0d", i));

    t_valid = 1'b0;
    @(posedge clk); #1;
    check("a.hold.vld",   32'(o_vld),   32'd0);
    check("a.hold.rdata", 32'(o_rdata), 32'hA5);
    check("a.hold.err",   32'(o_err),   32'd0);

    // Reset with a response in flight, then a second reset mid-clear
    apply('{1'b1, 8'h22, 8'h5A, 8'h5A, 1'b0}, "a.pre");
    apply('{1'b0, 8'h22, 8'h00, 8'h5A, 1'b0}, "a.inflight");
    rst[0] = 1'b1;
    @(posedge clk); #1;
    check("a.drop.vld",   32'(o_vld),   32'd0);
    check("a.drop.rdata", 32'(o_rdata), 32'd0);
    check("a.drop.busy",  32'(o_busy),  32'd1);
    rst[0] = 1'b0; t_valid = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("a.mid.busy", 32'(o_busy), 32'd1);
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    wait_ready(128, "a.clr2");
    for (int i = 0; i < 3; i++) apply(vz[i], $sformatf("a.zero%0d", i));
    t_valid = 1'b0;

    // Windowed config: BASE 0x40, DEPTH 16
    sel = 1;
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    wait_ready(16, "b.clr");
    for (int i = 0; i < 8; i++) apply(vb[i], $sformatf("b.vec%0d", i));
    t_valid = 1'b0;

    // No-clear config
    sel = 2;
    rst[2] = 1'b1;
    @(posedge clk); #1;
    check("c.rst.ready", 32'(o_ready), 32'd1);
    check("c.rst.busy",  32'(o_busy),  32'd0);
    rst[2] = 1'b0;
    apply('{1'b1, 8'h05, 8'h77, 8'h77, 1'b0}, "c.wr");
    apply('{1'b0, 8'h05, 8'h00, 8'h77, 1'b0}, "c.rd");
    t_valid = 1'b0;
    @(posedge clk); #1;
    check("c.idle.vld", 32'(o_vld), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_ram_ctrl.md
# data_ram_ctrl

Parametrised single-port data memory for the TI170 datapath, serving the load/store path with a valid/ready request interface, a registered response, an address-window decoder and a hardware clear sequence after reset. It sits between the execute stage and the data array. It generalises the fixed 8-bit/128-word data RAM with configurable width, depth and base address. It adds out-of-range error reporting and guaranteed-zero contents after reset.

## Interface
- DATA_W, 8, data word width in bits
- ADDR_W, 8, request address width in bits
- DEPTH, 128, number of words; 2 ≤ DEPTH ≤ 2**ADDR_W
- BASE_ADDR, 0, first address decoded by this block
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = skip the clear

Ports:
- clock  in  1  single clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block accepts a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte/word address (word-addressed)
- req_wdata  in  DATA_W  store data
- rsp_valid  out  1  one-cycle pulse, response for the request accepted on the previous edge
- rsp_rdata  out  DATA_W  load data, or store data echoed on a write
- rsp_err  out  1  accepted address was outside the window
- busy  out  1  clear sequence in progress

## Operation
- States: CLEAR and IDLE.
- Reset is sampled high → state = CLEAR if CLEAR_ON_RESET, else IDLE. On the same edge: clear counter = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
- CLEAR:
  - One word is zeroed per cycle at counter index; counter increments.
  - After writing index DEPTH-1 → IDLE.
  - busy = 1 and req_ready = 0 throughout.
- IDLE: req_ready = 1 and busy = 0. A request is accepted on any edge where req_valid && req_ready.
- Window decode: in_range = (req_addr ≥ BASE_ADDR) && (req_addr − BASE_ADDR < DEPTH). Index = req_addr − BASE_ADDR, truncated to clog2(DEPTH) bits. Compare at ADDR_W+1 bits so BASE_ADDR+DEPTH cannot wrap.
- Accepted write, in range: word is written at that edge. Next cycle: rsp_valid = 1, rsp_rdata = req_wdata, rsp_err = 0.
- Accepted read, in range: next cycle rsp_valid = 1 with rsp_rdata = the array word, rsp_err = 0.
- Accepted request, out of range: the array is not modified. Next cycle rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
- rsp_rdata and rsp_err hold their last value while rsp_valid = 0.
- There is no response backpressure. The consumer must take rsp_valid on the cycle it is asserted.
- Reset asserted mid-clear restarts the clear from index 0. Reset asserted with a request in flight drops the pending response (rsp_valid = 0 on the next cycle).

## Timing
- Request-to-response latency is exactly 1 cycle. Throughput is 1 request per cycle in IDLE.
- Read-after-write to the same address on back-to-back cycles returns the new data. The write commits at edge N; a read accepted at N+1 sees it.
- Clear duration: DEPTH cycles after the reset edge where reset is last high. With defaults, req_ready first rises 128 cycles after reset deasserts.
- Outputs are registered. req_ready and busy are decoded from the state register only, never from inputs.

## Structure
- Package ti170_mem_pkg holds:
  - the state enum (ST_CLEAR, ST_IDLE)
  - default DATA_W/ADDR_W/DEPTH constants shared with the CPU top
  - a function computing the index width, clog2(DEPTH)
- One sub-module, ram_sp: a single-port synchronous array with we/addr/wdata/rdata and 1-cycle read.
  - The clear logic muxes its address and data into ram_sp.
  - No reset inside the array.

## Test plan
- Reset with defaults → busy = 1 and req_ready = 0 for 128 cycles, then req_ready = 1. A read of each of addresses 0, 64 and 127 returns 0x00 with rsp_err = 0.
- Write 0xA5 to address 0x10, then a read of 0x10 on the next cycle → write response echoes 0xA5; read response the following cycle returns 0xA5, rsp_valid pulses twice.
- Write 0x3C to address 0x80 (out of range) → rsp_err = 1, rsp_rdata = 0x00. A subsequent read of 0x00 still returns 0x00, so no aliasing of the out-of-range write.
- BASE_ADDR = 0x40, DEPTH = 16: accesses at 0x3F and 0x50 → rsp_err = 1; accesses at 0x40 and 0x4F → in range, with 0x4F mapping to index 15.
- Reset pulsed at clear cycle 50 → busy stays 1 for 128 full cycles after the second reset. Memory is fully zeroed, including words written before the first reset.
- CLEAR_ON_RESET = 0 → req_ready = 1 on the first cycle after reset. A write of 0x77 to 0x05 followed by a read returns 0x77.
